// File: rtl/nco_capture_pkg.sv
// Shared types, widths and the memory word packing for the NCO capture controller.
package nco_capture_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LOCK = 2'd1,
      CAPTURE   = 2'd2,
      DONE      = 2'd3
   } state_t;

   localparam int ADDR_W_DEF = 14;
   localparam int SMP_W_DEF  = 36;
   localparam int MEM_W_DEF  = 64;
   localparam int DEC_W_DEF  = 8;
   localparam int SEQ_W      = 16;
   localparam int PAD_W      = MEM_W_DEF - SEQ_W - SMP_W_DEF;

   // Memory word layout: sequence stamp on top, zero pad, raw sample at the bottom.
   function automatic logic [MEM_W_DEF-1:0] pack_wdata(input logic [SEQ_W-1:0] seq,
                                                       input logic [SMP_W_DEF-1:0] smp);
      return {seq, {PAD_W{1'b0}}, smp};
   endfunction

endpackage

// File: rtl/nco_decimator.sv
// Decimation counter: accepts one valid sample, then skips the next i_decim valid samples.
module nco_decimator #(
   parameter int DEC_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic [DEC_W-1:0] i_decim,
   input  logic             i_clear,
   input  logic             i_enable,
   output logic             o_accept
);

   localparam logic [DEC_W-1:0] ONE = 1;

   logic [DEC_W-1:0] r_cnt;

   // Count every valid sample seen while enabled, wrapping after i_decim.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && i_valid) begin
         r_cnt <= (r_cnt == i_decim) ? '0 : r_cnt + ONE;
      end
   end

   assign o_accept = i_enable && i_valid && (r_cnt == '0);

endmodule

// File: rtl/nco_capture_ctrl.sv
// Captures decimated, sequence-stamped NCO samples into the on-chip memory's second port.
import nco_capture_pkg::*;

module nco_capture_ctrl #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int SMP_W  = SMP_W_DEF,
   parameter int MEM_W  = MEM_W_DEF,
   parameter int DEC_W  = DEC_W_DEF
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic              ring_mode,
   input  logic [ADDR_W-1:0] capture_len,
   input  logic [DEC_W-1:0]  decim,
   input  logic              pll_locked,
   input  logic [SMP_W-1:0]  nco_out_data,
   input  logic              nco_out_valid,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_clken,
   output logic              mem_write,
   output logic [MEM_W-1:0]  mem_writedata,
   output logic [7:0]        mem_byteenable,
   output logic              busy,
   output logic              done,
   output logic              lock_err,
   output logic              wrapped,
   output logic [ADDR_W:0]   words_written
);

   localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   ONE_W   = 1;
   localparam logic [ADDR_W-1:0] ONE_A   = 1;
   localparam logic [ADDR_W-1:0] PTR_MAX = '1;
   localparam logic [SEQ_W-1:0]  ONE_S   = 1;

   state_t            r_state;
   state_t            w_next;
   logic              r_ring;
   logic [ADDR_W:0]   r_len;
   logic [DEC_W-1:0]  r_decim;
   logic [ADDR_W-1:0] r_ptr;
   logic [SEQ_W-1:0]  r_seq;
   logic [ADDR_W:0]   r_words;
   logic              r_lock_err;
   logic              r_wrapped;
   logic              r_write;
   logic              r_clken;
   logic [ADDR_W-1:0] r_addr;
   logic [MEM_W-1:0]  r_wdata;
   logic              w_start_ok;
   logic              w_cap_en;
   logic              w_accept;
   logic              w_last;

   assign w_start_ok = ((r_state == IDLE) || (r_state == DONE)) && start && !stop;
   assign w_cap_en   = (r_state == CAPTURE) && !stop && pll_locked;
   assign w_last     = !r_ring && (r_words == (r_len - ONE_W));

   nco_decimator #(.DEC_W(DEC_W)) u_decim (
      .i_clk    (clk_clk),
      .i_rst_n  (reset_reset_n),
      .i_valid  (nco_out_valid),
      .i_decim  (r_decim),
      .i_clear  (w_start_ok),
      .i_enable (w_cap_en),
      .o_accept (w_accept)
   );

   // State register.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state; the last single-shot accept moves to DONE on the edge that registers its write.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (w_start_ok) w_next = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (stop)            w_next = DONE;
            else if (pll_locked) w_next = CAPTURE;
         end
         CAPTURE: begin
            if (stop || !pll_locked)    w_next = DONE;
            else if (w_accept && w_last) w_next = DONE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Capture configuration, pointers, status flags and the registered memory write port.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_ring     <= 1'b0;
         r_len      <= '0;
         r_decim    <= '0;
         r_ptr      <= '0;
         r_seq      <= '0;
         r_words    <= '0;
         r_lock_err <= 1'b0;
         r_wrapped  <= 1'b0;
         r_write    <= 1'b0;
         r_clken    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_clken <= 1'b1;
         r_write <= w_accept;
         if (w_start_ok) begin
            r_ring     <= ring_mode;
            r_len      <= (capture_len == '0) ? DEPTH : {1'b0, capture_len};
            r_decim    <= decim;
            r_ptr      <= '0;
            r_seq      <= '0;
            r_words    <= '0;
            r_lock_err <= 1'b0;
            r_wrapped  <= 1'b0;
         end
         if ((r_state == CAPTURE) && !pll_locked) begin
            r_lock_err <= 1'b1;
         end
         if (w_accept) begin
            r_addr  <= r_ptr;
            r_wdata <= pack_wdata(r_seq, nco_out_data);
            r_ptr   <= r_ptr + ONE_A;
            r_seq   <= r_seq + ONE_S;
            if (r_words != DEPTH) r_words <= r_words + ONE_W;
            if (r_ring && (r_ptr == PTR_MAX)) r_wrapped <= 1'b1;
         end
      end
   end

   assign mem_address    = r_addr;
   assign mem_write      = r_write;
   assign mem_chipselect = r_write;
   assign mem_byteenable = r_write ? 8'hFF : 8'h00;
   assign mem_writedata  = r_wdata;
   assign mem_clken      = r_clken;
   assign busy           = (r_state == WAIT_LOCK) || (r_state == CAPTURE);
   assign done           = (r_state == DONE);
   assign lock_err       = r_lock_err;
   assign wrapped        = r_wrapped;
   assign words_written  = r_words;

endmodule

// File: tb/tb_nco_capture_ctrl.sv
// Directed and randomized bench for nco_capture_ctrl against a transaction-level reference model.
module tb_nco_capture_ctrl;

   localparam int AW    = 3;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk_clk = 1'b0;
   logic          reset_reset_n;
   logic          start, stop, ring_mode, pll_locked, nco_out_valid;
   logic [AW-1:0] capture_len;
   logic [DW-1:0] decim;
   logic [35:0]   nco_out_data;
   logic [AW-1:0] mem_address;
   logic          mem_chipselect, mem_clken, mem_write;
   logic [63:0]   mem_writedata;
   logic [7:0]    mem_byteenable;
   logic          busy, done, lock_err, wrapped;
   logic [AW:0]   words_written;

   int nVec = 0;
   int nErr = 0;

   // Reference model: phase 0 idle, 1 waiting for lock, 2 capturing, 3 finished.
   int          mPhase = 0;
   int          mValidCnt, mAcc, mLen, mDecim, mLastAddr;
   bit          mRing, mLockErr, mWrapped, mClken, eWrite;
   logic [63:0] eData;

   nco_capture_ctrl #(.ADDR_W(AW), .SMP_W(36), .MEM_W(64), .DEC_W(DW)) dut (
      .clk_clk        (clk_clk),
      .reset_reset_n  (reset_reset_n),
      .start          (start),
      .stop           (stop),
      .ring_mode      (ring_mode),
      .capture_len    (capture_len),
      .decim          (decim),
      .pll_locked     (pll_locked),
      .nco_out_data   (nco_out_data),
      .nco_out_valid  (nco_out_valid),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_clken      (mem_clken),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_byteenable (mem_byteenable),
      .busy           (busy),
      .done           (done),
      .lock_err       (lock_err),
      .wrapped        (wrapped),
      .words_written  (words_written)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] rndData();
      logic [35:0] d;
      d[31:0]  = $urandom;
      d[35:32] = 4'($urandom);
      return d;
   endfunction

   // Predict the effect of one clock edge given the inputs currently driven.
   task automatic applyStimulus(input bit rn, input bit st, input bit sp, input bit lk,
                                input bit vl, input logic [35:0] dat);
      int addr;
      reset_reset_n = rn; start = st; stop = sp; pll_locked = lk;
      nco_out_valid = vl; nco_out_data = dat;
      eWrite = 1'b0;
      if (!rn) begin
         mPhase = 0; mAcc = 0; mLastAddr = 0; mLockErr = 0; mWrapped = 0; mClken = 0;
      end else begin
         mClken = 1;
         if ((mPhase == 0 || mPhase == 3) && st && !sp) begin
            mRing = ring_mode;
            mLen = (capture_len == '0) ? DEPTH : int'(capture_len);
            mDecim = int'(decim);
            mValidCnt = 0; mAcc = 0; mLockErr = 0; mWrapped = 0;
            mPhase = 1;
         end else if (mPhase == 1) begin
            if (sp) mPhase = 3;
            else if (lk) mPhase = 2;
         end else if (mPhase == 2) begin
            if (sp || !lk) begin
               mPhase = 3;
               if (!lk) mLockErr = 1;
            end else if (vl) begin
               if (mValidCnt % (mDecim + 1) == 0) begin
                  addr = mAcc % DEPTH;
                  eWrite = 1'b1;
                  eData = {16'(mAcc), 12'h000, dat};
                  mLastAddr = addr;
                  if (mRing && addr == DEPTH - 1) mWrapped = 1;
                  mAcc++;
                  if (!mRing && mAcc == mLen) mPhase = 3;
               end
               mValidCnt++;
            end
         end
      end
      @(posedge clk_clk);
      #1;
      checkOutput();
   endtask

   task automatic checkOutput();
      int expWords;
      expWords = (mAcc > DEPTH) ? DEPTH : mAcc;
      chk("mem_write", 64'(mem_write), 64'(eWrite));
      chk("mem_chipselect", 64'(mem_chipselect), 64'(eWrite));
      chk("mem_byteenable", 64'(mem_byteenable), eWrite ? 64'hFF : 64'h0);
      chk("mem_address", 64'(mem_address), 64'(mLastAddr));
      if (eWrite) chk("mem_writedata", mem_writedata, eData);
      chk("mem_clken", 64'(mem_clken), 64'(mClken));
      chk("busy", 64'(busy), 64'(mPhase == 1 || mPhase == 2));
      chk("done", 64'(done), 64'(mPhase == 3));
      chk("lock_err", 64'(lock_err), 64'(mLockErr));
      chk("wrapped", 64'(wrapped), 64'(mWrapped));
      chk("words_written", 64'(words_written), 64'(expWords));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 1, 0, '0);
   endtask

   initial begin
      ring_mode = 0; capture_len = '0; decim = '0;

      // Reset state.
      applyStimulus(0, 0, 0, 1, 0, '0);
      applyStimulus(0, 0, 0, 1, 0, '0);
      idle(1);

      // Single-shot, no decimation, four words from samples 1..5.
      ring_mode = 0; capture_len = 3'd4; decim = 8'd0;
      applyStimulus(1, 1, 0, 1, 0, '0);
      applyStimulus(1, 0, 0, 1, 0, '0);
      for (int i = 1; i <= 5; i++) applyStimulus(1, 0, 0, 1, 1, 36'(i));
      idle(2);
      chk("s1_words", 64'(words_written), 64'd4);
      chk("s1_done", 64'(done), 64'd1);

      // Decimate by three: samples 10, 13, 16 land at 0, 1, 2.
      capture_len = 3'd3; decim = 8'd2;
      applyStimulus(1, 1, 0, 1, 0, '0);
      applyStimulus(1, 0, 0, 1, 0, '0);
      for (int i = 10; i <= 18; i++) applyStimulus(1, 0, 0, 1, 1, 36'(i));
      idle(2);
      chk("s2_last_addr", 64'(mem_address), 64'd2);

      // Ring mode: ten samples wrap the eight-word buffer, then stop.
      ring_mode = 1; capture_len = 3'd0; decim = 8'd0;
      applyStimulus(1, 1, 0, 1, 0, '0);
      applyStimulus(1, 0, 0, 1, 0, '0);
      for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 1, 1, rndData());
      applyStimulus(1, 0, 1, 1, 1, rndData());
      idle(2);
      chk("s3_wrapped", 64'(wrapped), 64'd1);
      chk("s3_words", 64'(words_written), 64'd8);
      chk("s3_done", 64'(done), 64'd1);

      // Lock low at start, raised later, then lost after two writes.
      ring_mode = 0; capture_len = 3'd0;
      applyStimulus(1, 1, 0, 0, 0, '0);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 1, rndData());
      applyStimulus(1, 0, 0, 1, 0, '0);
      applyStimulus(1, 0, 0, 1, 1, rndData());
      applyStimulus(1, 0, 0, 1, 1, rndData());
      applyStimulus(1, 0, 0, 0, 1, rndData());
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 1, rndData());
      chk("s4_lock_err", 64'(lock_err), 64'd1);
      chk("s4_words", 64'(words_written), 64'd2);

      // Start while capturing is ignored.
      capture_len = 3'd5; decim = 8'd1;
      applyStimulus(1, 1, 0, 1, 0, '0);
      applyStimulus(1, 0, 0, 1, 0, '0);
      applyStimulus(1, 0, 0, 1, 1, rndData());
      applyStimulus(1, 1, 0, 1, 1, rndData());
      for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 1, 1, rndData());
      idle(1);

      // Start together with stop in IDLE is ignored.
      applyStimulus(0, 0, 0, 1, 0, '0);
      applyStimulus(1, 1, 1, 1, 0, '0);
      idle(1);
      chk("s5_idle_busy", 64'(busy), 64'd0);

      // Reset on the edge that would register an accepted sample.
      ring_mode = 1; decim = 8'd0;
      applyStimulus(1, 1, 0, 1, 0, '0);
      applyStimulus(1, 0, 0, 1, 0, '0);
      applyStimulus(1, 0, 0, 1, 1, rndData());
      applyStimulus(1, 0, 0, 1, 1, rndData());
      applyStimulus(0, 0, 0, 1, 1, rndData());
      chk("s6_no_write", 64'(mem_write), 64'd0);
      idle(2);

      // Randomized captures with random configuration, gaps, stops and lock drops.
      for (int run = 0; run < 20; run++) begin
         ring_mode   = 1'($urandom_range(0, 1));
         capture_len = 3'($urandom);
         decim       = 8'($urandom_range(0, 3));
         applyStimulus(1, 1, 0, 1'($urandom_range(0, 3) != 0), 0, '0);
         for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 9) < 7), rndData());
         end
         applyStimulus(1, 0, 1, 1, 0, '0);
         idle(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
